// File: rtl/store_buffer.sv
// store_buffer: a FIFO that queues pipeline stores and writes them into a byte-addressed
// data memory. Loads that exactly hit a queued store get its data forwarded. Loads that
// partially overlap a queued store stall. The block arbitrates the single memory port
// between loads (reads) and drains (writes).
module store_buffer #(
  parameter int unsigned Depth = 4
) (
  input  logic                    clock,
  input  logic                    ResetN,
  input  logic                    StoreValid,
  input  logic [31:0]             StoreAddress,
  input  logic [31:0]             StoreData,
  output logic                    StoreReady,
  input  logic                    LoadValid,
  input  logic [31:0]             LoadAddress,
  output logic [31:0]             LoadData,
  output logic                    LoadHit,
  output logic                    LoadStall,
  output logic                    MemoryRead,
  output logic                    MemoryWrite,
  output logic [31:0]             MemAddress,
  output logic [31:0]             MemWriteData,
  input  logic [31:0]             MemReadData,
  output logic [$clog2(Depth):0]  Count,
  output logic                    Empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [31:0]     addr_q [Depth];
  logic [31:0]     data_q [Depth];
  logic [PtrW-1:0] head_q, tail_q;
  logic [PtrW:0]   count_q;

  logic            full, push, drain, load_own;
  logic            overlap, overlap_exact;
  logic [31:0]     overlap_data;
  logic [PtrW-1:0] idx;
  logic [31:0]     diff;

  assign full       = (count_q == (PtrW+1)'(Depth));
  assign push       = StoreValid & ~full;
  assign StoreReady = ~full;
  assign Count      = count_q;
  assign Empty      = (count_q == '0);

  // Scan valid entries oldest to youngest; the last overlapping one (youngest) wins.
  always_comb begin
    overlap       = 1'b0;
    overlap_exact = 1'b0;
    overlap_data  = '0;
    idx           = '0;
    diff          = '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      idx  = head_q + PtrW'(k);
      diff = LoadAddress - addr_q[idx];
      if ((PtrW+1)'(k) < count_q) begin
        // Word accesses overlap when the byte distance is within +/-3 (mod 2^32).
        if (diff == 32'd0) begin
          overlap       = 1'b1;
          overlap_exact = 1'b1;
          overlap_data  = data_q[idx];
        end else if (diff <= 32'd3 || diff >= 32'hFFFF_FFFD) begin
          overlap       = 1'b1;
          overlap_exact = 1'b0;
          overlap_data  = '0;
        end
      end
    end
  end

  // Load resolution and memory port arbitration; a non-overlapping load owns the port.
  always_comb begin
    load_own     = LoadValid & ~overlap;
    drain        = ~load_own & (count_q != '0);
    LoadHit      = 1'b0;
    LoadStall    = 1'b0;
    LoadData     = '0;
    MemoryRead   = 1'b0;
    MemoryWrite  = 1'b0;
    MemAddress   = '0;
    MemWriteData = '0;
    if (LoadValid) begin
      if (overlap && overlap_exact) begin
        LoadHit  = 1'b1;
        LoadData = overlap_data;
      end else if (overlap) begin
        LoadStall = 1'b1;
      end else begin
        LoadData = MemReadData;
      end
    end
    if (load_own) begin
      MemoryRead = 1'b1;
      MemAddress = LoadAddress;
    end else if (drain) begin
      MemoryWrite  = 1'b1;
      MemAddress   = addr_q[head_q];
      MemWriteData = data_q[head_q];
    end
  end

  // Pointer and occupancy state; reset discards all queued stores.
  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)  tail_q <= tail_q + 1'b1;
      if (drain) head_q <= head_q + 1'b1;
      if (push && !drain)      count_q <= count_q + 1'b1;
      else if (!push && drain) count_q <= count_q - 1'b1;
    end
  end

  // Entry payload needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= StoreAddress;
      data_q[tail_q] <= StoreData;
    end
  end

endmodule
